// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : Single-cycle-latency integer ALU (ADD/SUB/AND/OR/XOR/SLL/SRA)
//             with registered result and valid flag.
//  Revision : 1.0
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_ALUOp,
    input  logic [WIDTH-1:0] i_operand0,
    input  logic [WIDTH-1:0] i_operand1,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_XOR = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_SRA = 3'b111;

    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_result;
    logic             w_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    // Only the low five bits of B select the shift distance.
    assign w_shamt = i_operand1[4:0];

    always_comb begin
        w_result = '0;
        w_valid  = 1'b0;
        case (i_ALUOp)
            c_OP_ADD: begin
                w_valid  = 1'b1;
                w_result = i_operand0 + i_operand1;
            end
            c_OP_SUB: begin
                w_valid  = 1'b1;
                w_result = i_operand0 - i_operand1;
            end
            c_OP_AND: begin
                w_valid  = 1'b1;
                w_result = i_operand0 & i_operand1;
            end
            c_OP_OR: begin
                w_valid  = 1'b1;
                w_result = i_operand0 | i_operand1;
            end
            c_OP_XOR: begin
                w_valid  = 1'b1;
                w_result = i_operand0 ^ i_operand1;
            end
            c_OP_SLL: begin
                w_valid  = 1'b1;
                w_result = i_operand0 << w_shamt;
            end
            c_OP_SRA: begin
                w_valid  = 1'b1;
                w_result = $signed(i_operand0) >>> w_shamt;
            end
            // NOP and any opcode with X/Z bits fall here: invalid, zero data.
            default: begin
                w_result = '0;
                w_valid  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid  <= w_valid;
            r_result <= w_result;
        end
    end

    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Self-checking bench for alu: behavioural model compared every
//             cycle, plus literal expectations on directed vectors.
//  Revision : 1.0
// ============================================================================
module tb_alu;

    localparam int WIDTH = 32;

    logic             i_clk;
    logic             i_rst_n;
    logic [2:0]       i_ALUOp;
    logic [WIDTH-1:0] i_operand0;
    logic [WIDTH-1:0] i_operand1;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;

    int n_checks = 0;
    int n_pass   = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ALUOp    (i_ALUOp),
        .i_operand0 (i_operand0),
        .i_operand1 (i_operand1),
        .o_valid    (o_valid),
        .o_result   (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference behaviour from the operation definitions, using plain arithmetic.
    function automatic logic [WIDTH-1:0] model(input logic rst_n, input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               output logic v);
        int unsigned sh;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] mask;
        v = 1'b0;
        if (!rst_n || $isunknown(op) || op == 3'd0) return '0;
        v  = 1'b1;
        sh = b % 32;
        case (op)
            3'd1: r = a + b;
            3'd2: r = a - b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin
                r = a;
                for (int i = 0; i < int'(sh); i++) r = r * 2;
            end
            default: begin
                // Arithmetic shift: flip negative values, shift logically, flip back.
                mask = a[WIDTH-1] ? '1 : '0;
                r = ((a ^ mask) / (64'd1 << sh)) ^ mask;
            end
        endcase
        return r;
    endfunction

    // Compare process: expectation from inputs sampled at each edge.
    always @(posedge i_clk) begin
        logic             ev;
        logic [WIDTH-1:0] er;
        er = model(i_rst_n, i_ALUOp, i_operand0, i_operand1, ev);
        #1;
        chk($sformatf("model_valid op=%b", i_ALUOp), {63'd0, o_valid}, {63'd0, ev});
        chk("model_result", {32'd0, o_result}, {32'd0, er});
    end

    task automatic step(input logic rst_n, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        i_rst_n    = rst_n;
        i_ALUOp    = op;
        i_operand0 = a;
        i_operand1 = b;
        @(posedge i_clk);
        #2;
    endtask

    task automatic lit(input string name, input logic v, input logic [WIDTH-1:0] r);
        chk({name, "_valid"}, {63'd0, o_valid}, {63'd0, v});
        chk({name, "_result"}, {32'd0, o_result}, {32'd0, r});
    endtask

    initial begin
        i_rst_n = 1'b0; i_ALUOp = 3'd1; i_operand0 = 32'd5; i_operand1 = 32'd7;

        step(1'b0, 3'd1, 32'd5, 32'd7);           lit("reset1", 1'b0, 32'd0);
        step(1'b0, 3'd1, 32'd5, 32'd7);           lit("reset2", 1'b0, 32'd0);
        step(1'b1, 3'd1, 32'd5, 32'd7);           lit("release_add", 1'b1, 32'd12);

        step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd1);   lit("add_wrap", 1'b1, 32'h0000_0000);
        step(1'b1, 3'd2, 32'd0, 32'd1);           lit("sub_wrap", 1'b1, 32'hFFFF_FFFF);

        step(1'b1, 3'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F); lit("and", 1'b1, 32'h00F0_000F);
        step(1'b1, 3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F); lit("or",  1'b1, 32'hFFF0_0FFF);
        step(1'b1, 3'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F); lit("xor", 1'b1, 32'hFF00_0FF0);

        step(1'b1, 3'd6, 32'd1, 32'h0000_0024);         lit("sll", 1'b1, 32'h10);
        step(1'b1, 3'd6, 32'h0000_0003, 32'hFFFF_FFE1); lit("sll_hib", 1'b1, 32'h6);
        step(1'b1, 3'd7, 32'h8000_0000, 32'd31);        lit("sra_neg", 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 3'd7, 32'h4000_0000, 32'd30);        lit("sra_pos", 1'b1, 32'd1);
        step(1'b1, 3'd7, 32'hF000_0000, 32'd4);         lit("sra_neg4", 1'b1, 32'hFF00_0000);

        step(1'b1, 3'd1, 32'd2, 32'd3);           lit("b2b_add", 1'b1, 32'd5);
        step(1'b1, 3'd2, 32'd9, 32'd4);           lit("b2b_sub", 1'b1, 32'd5);
        step(1'b1, 3'd0, 32'd9, 32'd4);           lit("b2b_nop", 1'b0, 32'd0);
        step(1'b1, 3'd5, 32'd6, 32'd3);           lit("b2b_xor", 1'b1, 32'd5);

        // Unknown opcode: checked by the model against whatever the bench drove.
        step(1'b1, 3'bxxx, 32'd6, 32'd3);
        step(1'b1, 3'd1, 32'd100, 32'd1);         lit("pre_rst", 1'b1, 32'd101);
        step(1'b0, 3'd1, 32'd100, 32'd1);         lit("mid_rst", 1'b0, 32'd0);
        step(1'b1, 3'd2, 32'd100, 32'd1);         lit("post_rst", 1'b1, 32'd99);

        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        @(posedge i_clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (one machine word).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_ALUOp, input, 3 bits: operation select.
REQ-005 SHALL have port i_operand0, input, WIDTH bits: first operand (A).
REQ-006 SHALL have port i_operand1, input, WIDTH bits: second operand (B), already muxed between register and immediate by the caller.
REQ-007 SHALL have port o_valid, output, 1 bit: o_result holds a valid computed value.
REQ-008 SHALL have port o_result, output, WIDTH bits: operation result.

Function
REQ-009 SHALL decode i_ALUOp as follows: 000 NOP, 001 ADD (A+B), 010 SUB (A-B), 011 AND, 100 OR, 101 XOR, 110 SLL (A << B[4:0]), 111 SRA (A >>> B[4:0], arithmetic).
REQ-010 SHALL treat all operands as two's-complement WIDTH-bit values, truncate ADD and SUB results to WIDTH bits, and neither detect nor flag overflow or carry.
REQ-011 SHALL use only B[4:0] as the shift amount for SLL and SRA and ignore the upper bits of B.
REQ-012 SHALL, for SRA, replicate A[WIDTH-1] into the vacated high bits.
REQ-013 SHALL register o_result and o_valid with a latency of exactly 1 cycle: the inputs sampled at rising edge N appear on the outputs after edge N.
REQ-014 SHALL compute a new result every cycle, with no stall, handshake, or back-pressure; throughput is 1 operation per cycle.
REQ-015 SHALL, for opcodes 001-111, set o_valid=1 and o_result=result on the next edge.
REQ-016 SHALL, for opcode 000 (NOP), set o_valid=0 and o_result=0 on the next edge.
REQ-017 SHALL treat an i_ALUOp that contains X or Z bits as a NOP (o_valid=0, o_result=0) in simulation, and SHALL never assert o_valid with X data.
REQ-018 SHALL keep o_result a pure function of the sampled inputs, with no internal accumulation or other state beyond the output registers.

Reset
REQ-019 SHALL, on any rising edge where i_rst_n=0, set o_valid=0 and o_result=0, regardless of other inputs.
REQ-020 SHALL, on the first edge with i_rst_n=1, produce outputs from the inputs sampled at that edge.
REQ-021 SHALL, when reset is asserted mid-stream, discard any in-flight result; no result is produced for inputs sampled while i_rst_n=0.
REQ-022 SHALL not require an initial block for correct behaviour after reset.

Verification
REQ-023 SHALL pass this scenario: reset held 2 cycles with op=001, A=5, B=7 -> o_valid=0, o_result=0; release -> next edge o_valid=1, o_result=12.
REQ-024 SHALL pass this scenario: ADD A=0xFFFFFFFF, B=1 -> 0x00000000, valid=1; SUB A=0, B=1 -> 0xFFFFFFFF.
REQ-025 SHALL pass this scenario: AND/OR/XOR with A=0xF0F0_00FF, B=0x0FF0_0F0F -> 0x00F0_000F, 0xFFF0_0FFF, 0xFF00_0FF0 respectively.
REQ-026 SHALL pass this scenario: SLL A=1, B=0x0000_0024 (shamt 4) -> 0x10; SRA A=0x8000_0000, B=31 -> 0xFFFF_FFFF; SRA A=0x4000_0000, B=30 -> 1.
REQ-027 SHALL pass this scenario: back-to-back ops every cycle (ADD 2+3, SUB 9-4, NOP, XOR 6^3) -> outputs 5/v1, 5/v1, 0/v0, 5/v1 on consecutive edges.
REQ-028 SHALL pass this scenario: i_ALUOp=3'bxxx -> o_valid=0, o_result=0; reset asserted during a stream -> outputs 0/0 on that edge.
